// File: rtl/chronologic_pkg.sv
// Shared types for the a |-> ##1 b ##1 c run-time checker.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents: default widths, the attempt record, the per-stage verdict
// encoding and the fail-increment helper used by the top.
package chronologic_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int TS_W_DEF  = 16;

  // Default-width view of one in-flight attempt. The top declares a
  // same-shaped local type sized by its own TS_W parameter.
  typedef struct packed {
    logic                vld;
    logic [TS_W_DEF-1:0] ts;
  } attempt_t;

  typedef enum logic [1:0] {
    V_NONE   = 2'd0,
    V_PASS   = 2'd1,
    V_FAIL_B = 2'd2,
    V_FAIL_C = 2'd3
  } verdict_t;

  // Number of failures decided on one edge (0, 1 or 2).
  function automatic logic [1:0] fail_inc(input logic fb, input logic fc);
    return {1'b0, fb} + {1'b0, fc};
  endfunction

endpackage

// File: rtl/chronologic_sat_cnt.sv
// Saturating event counter, increment 0..2 per cycle, synchronous clear.
// Latency: count reflects the increment one edge after it is presented.
// Backpressure: none; sticks at all-ones instead of wrapping.
//
// Ports:
//   clk  in   1  rising-edge clock
//   rst  in   1  synchronous active-high reset (priority over clr)
//   clr  in   1  synchronous clear; beats a same-cycle increment
//   inc  in   2  amount to add this edge
//   cnt  out  W  current count (registered)
module chronologic_sat_cnt #(
  parameter int W = 16  // must be >= 2 so an increment of 2 fits
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  always_comb begin
    // One extra bit catches the carry out of the top, which means saturation.
    sum = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc};
    if (clr) begin
      cnt_d = '0;
    end else if (sum[W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/chronologic.sv
// Run-time checker for a |-> ##1 b ##1 c with overlapping attempts.
// Latency: verdict decided from samples at edge k is visible right after edge k.
// Backpressure: none; observes only, never stalls the monitored logic.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              allows new attempts to start (in-flight ones always finish)
//   clr             zeroes pass_cnt, fail_cnt, fail_seen
//   a, b, c         antecedent and the two consequents
//   pass            pulse: attempt saw b then c
//   fail_b          pulse: attempt saw b=0 one cycle after start
//   fail_c          pulse: attempt saw b=1 then c=0
//   fail_ts         start timestamp of the failing attempt (oldest wins)
//   pass_cnt        saturating pass total
//   fail_cnt        saturating failure total
//   fail_seen       sticky: any failure since reset/clr
module chronologic
  import chronologic_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             pass,
  output logic             fail_b,
  output logic             fail_c,
  output logic [TS_W-1:0]  fail_ts,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen
);

  // Same shape as attempt_t, sized by this instance's TS_W.
  typedef struct packed {
    logic            vld;
    logic [TS_W-1:0] ts;
  } stage_t;

  logic [TS_W-1:0] ts_q, ts_d;
  stage_t          p1_q, p1_d;   // attempt awaiting b
  stage_t          p2_q, p2_d;   // attempt awaiting c
  logic            pass_q, pass_d;
  logic            fail_b_q, fail_b_d;
  logic            fail_c_q, fail_c_d;
  logic [TS_W-1:0] fail_ts_q, fail_ts_d;
  logic            fail_seen_q, fail_seen_d;
  verdict_t        v1, v2;

  always_comb begin
    ts_d = ts_q + TS_W'(1);

    p1_d.vld = en & a;
    p1_d.ts  = ts_q;
    p2_d.vld = p1_q.vld & b;
    p2_d.ts  = p1_q.ts;

    // The two stages resolve independently, so a fail_b from the younger
    // attempt can coincide with a pass or fail_c from the older one.
    v1 = (p1_q.vld & ~b) ? V_FAIL_B : V_NONE;
    if (p2_q.vld) begin
      v2 = c ? V_PASS : V_FAIL_C;
    end else begin
      v2 = V_NONE;
    end

    pass_d   = (v2 == V_PASS);
    fail_b_d = (v1 == V_FAIL_B);
    fail_c_d = (v2 == V_FAIL_C);

    // Report the older attempt when both fail on the same edge.
    fail_ts_d = fail_ts_q;
    if (fail_c_d) begin
      fail_ts_d = p2_q.ts;
    end else if (fail_b_d) begin
      fail_ts_d = p1_q.ts;
    end

    // clr beats a coincident failure.
    if (clr) begin
      fail_seen_d = 1'b0;
    end else begin
      fail_seen_d = fail_seen_q | fail_b_d | fail_c_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      pass_q      <= 1'b0;
      fail_b_q    <= 1'b0;
      fail_c_q    <= 1'b0;
      fail_ts_q   <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      pass_q      <= pass_d;
      fail_b_q    <= fail_b_d;
      fail_c_q    <= fail_c_d;
      fail_ts_q   <= fail_ts_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  // Counters take the same-edge verdicts so totals line up with the pulses.
  chronologic_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc ({1'b0, pass_d}),
    .cnt (pass_cnt)
  );

  chronologic_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (fail_inc(fail_b_d, fail_c_d)),
    .cnt (fail_cnt)
  );

  assign pass      = pass_q;
  assign fail_b    = fail_b_q;
  assign fail_c    = fail_c_q;
  assign fail_ts   = fail_ts_q;
  assign fail_seen = fail_seen_q;

endmodule

// File: tb/tb_chronologic.sv
module tb_chronologic;

  logic clk = 1'b0;
  logic rst, en, clr, a, b, c;

  logic        pass, fail_b, fail_c, fail_seen;
  logic [15:0] fail_ts, pass_cnt, fail_cnt;

  logic       s_pass, s_fail_b, s_fail_c, s_fail_seen;
  logic [1:0] s_fail_ts, s_pass_cnt, s_fail_cnt;

  always #5 clk = ~clk;

  chronologic dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .pass(pass), .fail_b(fail_b), .fail_c(fail_c), .fail_ts(fail_ts),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen)
  );

  chronologic #(.CNT_W(2), .TS_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .pass(s_pass), .fail_b(s_fail_b), .fail_c(s_fail_c), .fail_ts(s_fail_ts),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .fail_seen(s_fail_seen)
  );

  typedef struct {
    int   edge_no;
    logic pass;
    logic fb;
    logic fc;
    int   fts;
    int   pc;
    int   fcnt;
    logic seen;
  } ev_t;

  ev_t sb[$];
  ev_t mon_x;
  int  tests = 0;
  int  fails = 0;
  int  e;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic push(input int en_no, input logic p, input logic fb, input logic fc,
                      input int fts, input int pc, input int fcnt, input logic seen);
    ev_t x;
    x.edge_no = en_no; x.pass = p; x.fb = fb; x.fc = fc;
    x.fts = fts; x.pc = pc; x.fcnt = fcnt; x.seen = seen;
    sb.push_back(x);
  endtask

  // Apply one vector; it is sampled at the next posedge, which becomes edge e.
  task automatic step(input logic ai, input logic bi, input logic ci,
                      input logic eni = 1'b1, input logic clri = 1'b0,
                      input logic rsti = 1'b0);
    a = ai; b = bi; c = ci; en = eni; clr = clri; rst = rsti;
    @(posedge clk);
    e++;
    #1;
  endtask

  // Monitor: any pulse on the default instance must match the oldest expectation.
  always @(negedge clk) begin
    if (pass === 1'b1 || fail_b === 1'b1 || fail_c === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_x = sb.pop_front();
        chk("pulse_edge", e, mon_x.edge_no);
        chk("pass", pass, mon_x.pass);
        chk("fail_b", fail_b, mon_x.fb);
        chk("fail_c", fail_c, mon_x.fc);
        chk("fail_ts", fail_ts, mon_x.fts);
        chk("pass_cnt", pass_cnt, mon_x.pc);
        chk("fail_cnt", fail_cnt, mon_x.fcnt);
        chk("fail_seen", fail_seen, mon_x.seen);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    e = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pass", pass, 0);
    chk("rst_fail_b", fail_b, 0);
    chk("rst_fail_c", fail_c, 0);
    chk("rst_fail_ts", fail_ts, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_fail_seen", fail_seen, 0);

    // Basic pass, then overlapping fail_c + fail_b.
    step(0,0,0);                                  // edge 0
    step(1,0,0); step(1,1,0); step(1,1,1);        // edges 1..3
    push(3, 1,0,0, 0, 1, 0, 0);
    step(0,0,0);                                  // edge 4
    push(4, 0,1,1, 2, 1, 2, 1);

    // Run of fail_b then fail_c.
    step(1,0,0);                                  // 5
    step(1,0,0); push(6,  0,1,0, 5, 1, 3, 1);
    step(1,0,1); push(7,  0,1,0, 6, 1, 4, 1);
    step(1,0,1); push(8,  0,1,0, 7, 1, 5, 1);
    step(1,1,1);                                  // 9
    step(1,1,0); push(10, 0,0,1, 8, 1, 6, 1);
    step(1,1,0); push(11, 0,0,1, 9, 1, 7, 1);
    @(negedge clk);
    chk("totals_pass_e11", pass_cnt, 1);
    chk("totals_fail_e11", fail_cnt, 7);
    step(0,0,0); push(12, 0,1,1, 10, 1, 9, 1);    // drain both stages
    step(0,0,0);                                  // 13

    // en=0 blocks starts; en dropped after a start still reports.
    step(1,1,1,0); step(0,1,1,0); step(0,1,1,0);  // 14..16
    step(1,0,0,1);                                // 17 start
    step(0,1,0,0);                                // 18
    step(0,0,1,0); push(19, 1,0,0, 10, 2, 9, 1);  // 19
    step(0,0,0,0);                                // 20

    // Reset with both stages occupied: everything discarded.
    step(1,0,0); step(1,1,0);                     // 21, 22
    step(1,1,1,1,0,1);                            // 23 rst edge
    @(negedge clk);
    chk("rst2_pass", pass, 0);
    chk("rst2_fail_b", fail_b, 0);
    chk("rst2_fail_c", fail_c, 0);
    chk("rst2_fail_ts", fail_ts, 0);
    chk("rst2_pass_cnt", pass_cnt, 0);
    chk("rst2_fail_cnt", fail_cnt, 0);
    chk("rst2_fail_seen", fail_seen, 0);
    step(0,1,1);                                  // 24: nothing started at rst edge

    // clr coinciding with a failure.
    step(1,0,0);                                  // 25, ts=1
    step(0,0,0); push(26, 0,1,0, 1, 0, 1, 1);
    step(1,0,0);                                  // 27, ts=3
    step(0,0,0,1,1); push(28, 0,1,0, 3, 0, 0, 0);
    step(0,0,0,1,1);                              // 29 clear both instances
    @(negedge clk);
    chk("clr_fail_cnt", fail_cnt, 0);
    chk("clr_s_fail_cnt", s_fail_cnt, 0);

    // Double failures every other edge; small instance saturates and wraps ts.
    step(1,0,0);                                  // 30 ts=6
    step(1,1,0);                                  // 31
    step(1,0,0); push(32, 0,1,1, 6, 0, 2, 1);
    @(negedge clk);
    chk("s_fail_b_e32", s_fail_b, 1);
    chk("s_fail_c_e32", s_fail_c, 1);
    chk("s_fail_ts_e32", s_fail_ts, 2);
    chk("s_fail_cnt_e32", s_fail_cnt, 2);
    step(1,1,0);
    step(1,0,0); push(34, 0,1,1, 8, 0, 4, 1);
    @(negedge clk);
    chk("s_fail_ts_e34", s_fail_ts, 0);
    chk("s_fail_cnt_e34", s_fail_cnt, 3);
    step(1,1,0);
    step(1,0,0); push(36, 0,1,1, 10, 0, 6, 1);
    @(negedge clk);
    chk("s_fail_ts_e36", s_fail_ts, 2);
    chk("s_fail_cnt_e36", s_fail_cnt, 3);
    step(1,1,0);
    step(1,0,0); push(38, 0,1,1, 12, 0, 8, 1);
    @(negedge clk);
    chk("s_fail_ts_e38", s_fail_ts, 0);
    chk("s_fail_cnt_e38", s_fail_cnt, 3);
    step(0,0,0); push(39, 0,1,0, 14, 0, 9, 1);
    @(negedge clk);
    chk("s_fail_ts_e39", s_fail_ts, 2);
    chk("s_fail_cnt_e39", s_fail_cnt, 3);
    step(0,0,0);                                  // 40
    @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    chk("final_pass_cnt", pass_cnt, 0);
    chk("final_fail_cnt", fail_cnt, 9);
    chk("s_pass_cnt", s_pass_cnt, 0);
    chk("s_fail_seen", s_fail_seen, 1);
    chk("s_pass_idle", s_pass, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
